// File: rtl/vector_vector_alu_mc_if.sv
// Stream, tracing and config-bus signals of the vector-vector ALU.
// master drives the stream and config bus; slave is the ALU side.
interface vector_vector_alu_mc_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHAIN_W    = 2
);
  logic                           tracing;
  logic                           valid_in;
  logic                           eof_in;
  logic                           bof_in;
  logic [CHAIN_W-1:0]             chainId_in;
  logic [7:0]                     configId;
  logic [7:0]                     configData;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic [CHAIN_W-1:0]             chainId_out;
  logic                           valid_out;
  logic                           eof_out;
  logic                           bof_out;

  modport master (
    output tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
    input  vector_out, chainId_out, valid_out, eof_out, bof_out
  );

  modport slave (
    input  tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
    output vector_out, chainId_out, valid_out, eof_out, bof_out
  );
endinterface

// File: rtl/vector_vector_alu_mc.sv
// Per-lane vector-vector ALU with a flop VRF, per-chain runtime firmware and
// write-to-read forwarding; fixed 2-cycle latency, one vector per cycle.
module vector_vector_alu_mc #(
  parameter int unsigned N                          = 8,
  parameter int unsigned DATA_WIDTH                 = 32,
  parameter int unsigned MAX_CHAINS                 = 4,
  parameter int unsigned VRF_SIZE                   = 8,
  parameter logic [7:0]  PERSONAL_CONFIG_ID         = 8'd0,
  parameter int unsigned SATURATE                   = 0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_OP         = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_ADDR_RD    = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND       = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_CACHE      = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_CACHE_ADDR = '0
) (
  input logic                  clk,
  input logic                  reset,
  vector_vector_alu_mc_if.slave bus
);
  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned CHAIN_W = $clog2(MAX_CHAINS);
  localparam int unsigned VRF_AW  = $clog2(VRF_SIZE);
  localparam logic [DW-1:0] SMAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN  = {1'b1, {(DW-1){1'b0}}};

  typedef logic [N-1:0][DW-1:0] vec_t;

  // Firmware tables; addresses keep only the bits that index the VRF
  logic [7:0]        fw_op         [MAX_CHAINS];
  logic [VRF_AW-1:0] fw_addr_rd    [MAX_CHAINS];
  logic [7:0]        fw_cond       [MAX_CHAINS];
  logic              fw_cache      [MAX_CHAINS];
  logic [VRF_AW-1:0] fw_cache_addr [MAX_CHAINS];
  logic [2:0]         cfg_field;
  logic [CHAIN_W-1:0] cfg_chain;

  vec_t vrf [VRF_SIZE];

  logic               s1_valid;
  logic               s1_eof;
  logic               s1_bof;
  logic [CHAIN_W-1:0] s1_chain;
  vec_t               s1_vec;
  vec_t               s1_operand;
  logic [7:0]         s1_op;
  logic [7:0]         s1_cond;
  logic               s1_cache;
  logic [VRF_AW-1:0]  s1_cache_addr;

  logic              cond_ok;
  vec_t              alu_res;
  logic              wr_en;
  logic [VRF_AW-1:0] wr_addr;
  logic [VRF_AW-1:0] rd_addr;

  function automatic logic [DW-1:0] sat_or_wrap(input logic [DW:0] x);
    if (SATURATE != 0 && x[DW] != x[DW-1]) return x[DW] ? SMIN : SMAX;
    return x[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] lane_alu(input logic [7:0] op, input logic [DW-1:0] v,
                                             input logic [DW-1:0] o);
    logic [DW:0] vx;
    logic [DW:0] ox;
    vx = {v[DW-1], v};
    ox = {o[DW-1], o};
    case (op)
      8'd1:    lane_alu = sat_or_wrap(vx + ox);
      8'd2:    lane_alu = v * o;
      8'd3:    lane_alu = sat_or_wrap(vx - ox);
      8'd4:    lane_alu = ($signed(v) > $signed(o)) ? v : o;
      8'd5:    lane_alu = ($signed(v) < $signed(o)) ? v : o;
      8'd6:    lane_alu = o;
      default: lane_alu = v;
    endcase
  endfunction

  // Config bus: walks op, addr_rd, cond, cache, cache_addr for each chain in turn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < MAX_CHAINS; c++) begin
        fw_op[c]         <= INITIAL_FIRMWARE_OP[8*c +: 8];
        fw_addr_rd[c]    <= INITIAL_FIRMWARE_ADDR_RD[8*c +: VRF_AW];
        fw_cond[c]       <= INITIAL_FIRMWARE_COND[8*c +: 8];
        fw_cache[c]      <= |INITIAL_FIRMWARE_CACHE[8*c +: 8];
        fw_cache_addr[c] <= INITIAL_FIRMWARE_CACHE_ADDR[8*c +: VRF_AW];
      end
      cfg_field <= 3'd0;
      cfg_chain <= '0;
    end else if (bus.configId == PERSONAL_CONFIG_ID) begin
      case (cfg_field)
        3'd0:    fw_op[cfg_chain]         <= bus.configData;
        3'd1:    fw_addr_rd[cfg_chain]    <= bus.configData[VRF_AW-1:0];
        3'd2:    fw_cond[cfg_chain]       <= bus.configData;
        3'd3:    fw_cache[cfg_chain]      <= |bus.configData;
        default: fw_cache_addr[cfg_chain] <= bus.configData[VRF_AW-1:0];
      endcase
      if (cfg_field == 3'd4) begin
        cfg_field <= 3'd0;
        cfg_chain <= cfg_chain + CHAIN_W'(1);
      end else begin
        cfg_field <= cfg_field + 3'd1;
      end
    end else begin
      cfg_field <= 3'd0;
      cfg_chain <= '0;
    end
  end

  // Stage-2 combinational datapath and VRF write decision
  always_comb begin
    cond_ok = 1'b0;
    case (s1_cond)
      8'd0:    cond_ok = 1'b1;
      8'd1:    cond_ok = s1_eof;
      8'd2:    cond_ok = !s1_eof;
      8'd3:    cond_ok = s1_bof;
      8'd4:    cond_ok = !s1_bof;
      default: cond_ok = 1'b0;
    endcase
    alu_res = '0;
    for (int unsigned l = 0; l < N; l++) begin
      alu_res[l] = lane_alu(s1_op, s1_vec[l], s1_operand[l]);
    end
    wr_en   = s1_valid && s1_cache && cond_ok && bus.tracing;
    wr_addr = s1_cache_addr;
    rd_addr = fw_addr_rd[bus.chainId_in];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < VRF_SIZE; i++) vrf[i] <= '0;
    end else if (wr_en) begin
      vrf[wr_addr] <= alu_res;
    end
  end

  // Stage 1: latch the vector with its chain's firmware; operand forwards a same-edge write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_eof        <= 1'b0;
      s1_bof        <= 1'b0;
      s1_chain      <= '0;
      s1_vec        <= '0;
      s1_operand    <= '0;
      s1_op         <= 8'd0;
      s1_cond       <= 8'd0;
      s1_cache      <= 1'b0;
      s1_cache_addr <= '0;
    end else begin
      s1_valid      <= bus.valid_in;
      s1_eof        <= bus.eof_in;
      s1_bof        <= bus.bof_in;
      s1_chain      <= bus.chainId_in;
      s1_vec        <= bus.vector_in;
      s1_operand    <= (wr_en && wr_addr == rd_addr) ? alu_res : vrf[rd_addr];
      s1_op         <= fw_op[bus.chainId_in];
      s1_cond       <= fw_cond[bus.chainId_in];
      s1_cache      <= fw_cache[bus.chainId_in];
      s1_cache_addr <= fw_cache_addr[bus.chainId_in];
    end
  end

  // Output register; data follows stage 2 even while tracing is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.vector_out  <= '0;
      bus.chainId_out <= '0;
      bus.valid_out   <= 1'b0;
      bus.eof_out     <= 1'b0;
      bus.bof_out     <= 1'b0;
    end else begin
      bus.vector_out  <= cond_ok ? alu_res : s1_vec;
      bus.chainId_out <= s1_chain;
      bus.valid_out   <= s1_valid && bus.tracing;
      bus.eof_out     <= s1_eof;
      bus.bof_out     <= s1_bof;
    end
  end
endmodule

// File: doc/vector_vector_alu_mc.md
Name: vector_vector_alu_mc

Overview:
Second-generation per-lane vector-vector ALU for the trace datapath. It combines each incoming N-lane vector with a vector held in an internal register file (VRF), and can write the result back into the VRF.
- Operation, condition and VRF addressing are per-chain firmware, reprogrammable at runtime over the config bus.
- Adds min/max, an optional signed saturating mode, and a flop-based VRF with write-to-read forwarding.
- Sits between the filter stage and the reduction stage of each trace chain.

Parameters:
N, 8, number of lanes.
DATA_WIDTH, 32, bits per lane.
MAX_CHAINS, 4, number of firmware chains (power of 2, >=2).
VRF_SIZE, 8, VRF depth in vectors (power of 2).
PERSONAL_CONFIG_ID, 0, configId value that addresses this block.
SATURATE, 0, 1 = signed saturating add/sub; 0 = modular arithmetic.
INITIAL_FIRMWARE_OP/ADDR_RD/COND/CACHE/CACHE_ADDR, all 0, per-chain reset values ([7:0] x MAX_CHAINS).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
tracing  in  1  1 = outputs and VRF writes enabled.
valid_in  in  1  input vector valid.
eof_in  in  1  last vector of frame.
bof_in  in  1  first vector of frame.
chainId_in  in  clog2(MAX_CHAINS)  chain selecting the firmware set.
configId  in  8  config target id.
configData  in  8  config byte.
vector_in  in  N x DATA_WIDTH  input lanes.
vector_out  out  N x DATA_WIDTH  result lanes.
chainId_out  out  clog2(MAX_CHAINS)  delayed chainId.
valid_out  out  1  output valid.
eof_out  out  1  delayed eof.
bof_out  out  1  delayed bof.

Behaviour:
Reset (asynchronous, immediate):
- All outputs 0.
- Pipeline valids 0.
- VRF cleared to 0.
- Firmware registers loaded from INITIAL_*.
- Config counter cleared to 0.
- A transaction in flight when reset asserts is dropped; it produces no output and no VRF write.

Pipeline (latency exactly 2 cycles, valid_in to valid_out, no stalls, one vector per cycle):
- Stage 1 registers:
  - vector_in, valid_in, eof_in, bof_in, chainId_in;
  - the chain's op, cond, cache and cache_addr;
  - operand = VRF[addr_rd[chainId_in]].
- Stage 2 computes alu_result per lane from v = stage-1 vector and o = operand. Ops:
  - 0 = v;
  - 1 = v+o;
  - 2 = low DATA_WIDTH bits of v*o;
  - 3 = v-o;
  - 4 = signed max(v,o);
  - 5 = signed min(v,o);
  - 6 = o;
  - 7..255 = v.
- SATURATE=1: ops 1 and 3 clamp to the signed range [-2^(DW-1), 2^(DW-1)-1]. Mul always truncates.
- Condition codes:
  - 0 = always;
  - 1 = eof;
  - 2 = !eof;
  - 3 = bof;
  - 4 = !bof;
  - >4 = never.
- Output register:
  - vector_out = cond_valid ? alu_result : v.
  - valid_out = stage-2 valid & tracing.
  - eof/bof/chainId outputs follow stage 2.
  - When tracing=0, the data outputs still update and valid_out=0.
- VRF write:
  - Occurs at the stage-2 clock edge when stage-2 valid & cache!=0 & cond_valid & tracing.
  - Writes alu_result to VRF[cache_addr].
  - Address bits above clog2(VRF_SIZE) are ignored; addresses wrap.
- Forwarding: if a stage-1 read address equals a same-cycle stage-2 write address, the operand register captures the write data, not the stale VRF entry. Back-to-back accumulate (op1, addr_rd==cache_addr) therefore accumulates every cycle.

Config bus:
- While configId==PERSONAL_CONFIG_ID, each cycle writes configData to firmware field k, then k increments.
- Order for k = 5*c + f: chain c = 0..MAX_CHAINS-1; field f = op, addr_rd, cond, cache, cache_addr.
- k wraps to 0 after 5*MAX_CHAINS-1.
- Any cycle with a different configId resets k to 0.
- Firmware changes take effect for vectors entering stage 1 on the following cycle. Vectors already in stage 1/2 keep their latched firmware.

Test Plan:
1. Reset, then valid_in=1, chain0 default op0, vector_in lanes=5 → two cycles later valid_out=1, lanes=5, VRF unchanged. Assert reset mid-stream → valid_out=0 immediately.
2. Program chain1 = {op1, addr_rd 2, cond0, cache1, cache_addr 2} via 5 config bytes at k=5..9. Stream 4 back-to-back vectors of lanes=3 → outputs 3, 6, 9, 12 (exercises forwarding).
3. SATURATE=1, DW=8, op1 with VRF lane=100, input 100 → output 127. Op3 with -100 minus 100 → -128. With SATURATE=0 → 200 mod 256 = -56 and 56.
4. Ops 4/5 with v=-3, o=2 → max 2, min -3. Op2 with 0x10000*0x10000, DW=32 → 0.
5. Cond 1 (eof), cache1: frame of 3 vectors, eof on the 3rd → only the 3rd is modified and written. The first two pass through unchanged with no VRF write.
6. tracing=0 with valid_in=1 and cache1 → valid_out=0 and no VRF write. Re-enable tracing → the VRF still holds its prior contents.
